alu_sequencer: RTL and testbench

- Multi-cycle control FSM for the Simple RISC Machine datapath. It sequences register-file reads into the A/B operand registers, drives the ALU opcode and operand selects, and writes back results.
- It decodes the opcode/op fields of the instruction register (MOV imm, MOV reg, ADD, CMP, AND, MVN) and signals readiness to the top level via w.
- It sits between the instruction register and the datapath that contains the ALU.

---
 rtl/alu_sequencer_if.sv | 44 ++++
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_sequencer_if
// Purpose : bundles the start/instruction-field inputs and the datapath
//           control outputs of the Simple RISC Machine control FSM.
// Signals :
//   s, opcode[2:0], op[1:0]        start pulse and instruction fields
//   w                              1 = sequencer idle and ready
//   nsel[2:0], vsel[1:0]           regfile select / writeback source
//   loada, loadb, loadc, loads     datapath register load enables
//   asel, bsel, ALUop[1:0]         ALU operand selects and operation
//   write, done, illegal           writeback enable and status pulses
// Modports: master drives the instruction side (top level / bench),
//           slave is the sequencer itself.
// ----------------------------------------------------------------------------
interface alu_sequencer_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic [1:0] ALUop;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       done;
    logic       illegal;

    modport master (
        output s, opcode, op,
        input  w, nsel, vsel, loada, loadb, asel, bsel, ALUop,
               loadc, loads, write, done, illegal
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, vsel, loada, loadb, asel, bsel, ALUop,
               loadc, loads, write, done, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Purpose : multi-cycle Moore control FSM for the Simple RISC Machine
//           datapath. Latches opcode/op on start, then walks the register
//           reads, ALU execute and writeback steps for MOV imm, MOV reg,
//           ADD, CMP, AND and MVN. Unsupported encodings raise a one-cycle
//           illegal pulse and return to idle.
// Ports   :
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_sequencer_if.slave (instruction inputs, datapath controls)
// ----------------------------------------------------------------------------
module alu_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_opcode;
    logic [1:0] r_op;

    logic w_isMovImm;
    logic w_isMovReg;
    logic w_isAlu;
    logic w_isCmp;
    logic w_isMvn;

    // Decode always looks at the latched copy so the instruction register
    // may change freely once the sequencer has accepted an instruction.
    assign w_isMovImm = (r_opcode == 3'b110) && (r_op == 2'b10);
    assign w_isMovReg = (r_opcode == 3'b110) && (r_op == 2'b00);
    assign w_isAlu    = (r_opcode == 3'b101);
    assign w_isCmp    = w_isAlu && (r_op == 2'b01);
    assign w_isMvn    = w_isAlu && (r_op == 2'b11);

    // State register plus the instruction-field latch. The fields are only
    // captured when a start is accepted in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_WAIT;
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
        end else begin
            r_state <= w_nextState;
            if ((r_state == ST_WAIT) && bus.s) begin
                r_opcode <= bus.opcode;
                r_op     <= bus.op;
            end
        end
    end

    // Next-state logic. MOV reg and MVN skip GET_A because their A operand
    // is forced to zero by asel; CMP has no writeback step.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_WAIT: begin
                if (bus.s) w_nextState = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_isMovImm)                w_nextState = ST_WRITE_IMM;
                else if (w_isMovReg || w_isMvn) w_nextState = ST_GET_B;
                else if (w_isAlu)              w_nextState = ST_GET_A;
                else                           w_nextState = ST_WAIT;
            end
            ST_GET_A:     w_nextState = ST_GET_B;
            ST_GET_B:     w_nextState = ST_EXEC;
            ST_EXEC:      w_nextState = w_isCmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: w_nextState = ST_WAIT;
            ST_WRITE_IMM: w_nextState = ST_WAIT;
            default:      w_nextState = ST_WAIT;
        endcase
    end

    // Moore output decode: everything defaults low, each state raises only
    // its own controls, so loads/writes can never overlap between states.
    always_comb begin
        bus.w       = 1'b0;
        bus.nsel    = 3'b000;
        bus.vsel    = 2'b00;
        bus.loada   = 1'b0;
        bus.loadb   = 1'b0;
        bus.asel    = 1'b0;
        bus.bsel    = 1'b0;
        bus.ALUop   = 2'b00;
        bus.loadc   = 1'b0;
        bus.loads   = 1'b0;
        bus.write   = 1'b0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        case (r_state)
            ST_WAIT: bus.w = 1'b1;
            ST_DECODE: begin
                bus.illegal = !(w_isMovImm || w_isMovReg || w_isAlu);
            end
            ST_GET_A: begin
                bus.nsel  = 3'b100;
                bus.loada = 1'b1;
            end
            ST_GET_B: begin
                bus.nsel  = 3'b001;
                bus.loadb = 1'b1;
            end
            ST_EXEC: begin
                bus.ALUop = w_isAlu ? r_op : 2'b00;
                bus.asel  = w_isMovReg || w_isMvn;
                if (w_isCmp) begin
                    bus.loads = 1'b1;
                    bus.done  = 1'b1;
                end else begin
                    bus.loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                bus.nsel  = 3'b010;
                bus.write = 1'b1;
                bus.done  = 1'b1;
            end
            ST_WRITE_IMM: begin
                bus.nsel  = 3'b100;
                bus.vsel  = 2'b01;
                bus.write = 1'b1;
                bus.done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
// Purpose : self-checking bench for alu_sequencer. Combines a table of
//           per-instruction summary vectors, hand-written corner sequences
//           and random instructions compared cycle by cycle against an
//           instruction-level reference model.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] ALUop;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [2:0] opcode;
        logic [1:0] op;
        int         busy;
        int         writes;
        int         illegals;
        int         execs;
        logic [1:0] aluop;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    outs_t expQ[$];
    outs_t waitOuts;
    vec_t  vecs[12];

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sampleOutputs();
        outs_t a;
        a.w       = bus.w;
        a.nsel    = bus.nsel;
        a.vsel    = bus.vsel;
        a.loada   = bus.loada;
        a.loadb   = bus.loadb;
        a.asel    = bus.asel;
        a.bsel    = bus.bsel;
        a.ALUop   = bus.ALUop;
        a.loadc   = bus.loadc;
        a.loads   = bus.loads;
        a.write   = bus.write;
        a.done    = bus.done;
        a.illegal = bus.illegal;
        return a;
    endfunction

    // Reference model: expected outputs for every busy cycle of one
    // instruction, derived from what the instruction needs to do.
    function automatic void buildExpected(input logic [2:0] oc, input logic [1:0] o);
        outs_t e;
        logic  isMovImm;
        logic  isMovReg;
        logic  isAlu;
        isMovImm = (oc == 3'd6) && (o == 2'd2);
        isMovReg = (oc == 3'd6) && (o == 2'd0);
        isAlu    = (oc == 3'd5);
        expQ.delete();
        e = '0;
        if (!(isMovImm || isMovReg || isAlu)) begin
            e.illegal = 1'b1;
            expQ.push_back(e);
            return;
        end
        expQ.push_back(e);
        if (isMovImm) begin
            e = '0; e.nsel = 3'b100; e.vsel = 2'b01; e.write = 1'b1; e.done = 1'b1;
            expQ.push_back(e);
            return;
        end
        if (isAlu && (o != 2'd3)) begin
            e = '0; e.nsel = 3'b100; e.loada = 1'b1;
            expQ.push_back(e);
        end
        e = '0; e.nsel = 3'b001; e.loadb = 1'b1;
        expQ.push_back(e);
        e = '0;
        e.ALUop = isMovReg ? 2'd0 : o;
        e.asel  = isMovReg || (o == 2'd3);
        if (isAlu && (o == 2'd1)) begin
            e.loads = 1'b1; e.done = 1'b1;
            expQ.push_back(e);
            return;
        end
        e.loadc = 1'b1;
        expQ.push_back(e);
        e = '0; e.nsel = 3'b010; e.write = 1'b1; e.done = 1'b1;
        expQ.push_back(e);
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one instruction from WAIT and compares each busy cycle with the
    // model. The instruction inputs are scrambled after the start edge, and
    // s is either held high or randomised, since both must be ignored.
    task automatic applyStimulus(input logic [2:0] oc, input logic [1:0] o, input logic keepS);
        bus.s      = 1'b1;
        bus.opcode = oc;
        bus.op     = o;
        checkOutput($sformatf("waitBefore_%0b_%0b", oc, o), sampleOutputs(), waitOuts);
        buildExpected(oc, o);
        stepCycle();
        bus.opcode = 3'($urandom);
        bus.op     = 2'($urandom);
        foreach (expQ[i]) begin
            checkOutput($sformatf("busy%0d_%0b_%0b", i, oc, o), sampleOutputs(), expQ[i]);
            bus.s = keepS ? 1'b1 : 1'($urandom);
            stepCycle();
        end
    endtask

    initial begin
        int busy;
        int writes;
        int illegals;
        int execs;
        logic [1:0] aluSeen;
        logic [2:0] oc;
        logic [1:0] o;

        checks   = 0;
        errors   = 0;
        waitOuts = '0;
        waitOuts.w = 1'b1;

        vecs[0]  = '{3'b110, 2'b10, 2, 1, 0, 0, 2'b00};
        vecs[1]  = '{3'b110, 2'b00, 4, 1, 0, 1, 2'b00};
        vecs[2]  = '{3'b101, 2'b00, 5, 1, 0, 1, 2'b00};
        vecs[3]  = '{3'b101, 2'b01, 4, 0, 0, 1, 2'b01};
        vecs[4]  = '{3'b101, 2'b10, 5, 1, 0, 1, 2'b10};
        vecs[5]  = '{3'b101, 2'b11, 4, 1, 0, 1, 2'b11};
        vecs[6]  = '{3'b000, 2'b00, 1, 0, 1, 0, 2'b00};
        vecs[7]  = '{3'b110, 2'b01, 1, 0, 1, 0, 2'b00};
        vecs[8]  = '{3'b110, 2'b11, 1, 0, 1, 0, 2'b00};
        vecs[9]  = '{3'b111, 2'b00, 1, 0, 1, 0, 2'b00};
        vecs[10] = '{3'b100, 2'b10, 1, 0, 1, 0, 2'b00};
        vecs[11] = '{3'b011, 2'b01, 1, 0, 1, 0, 2'b00};

        // Reset held for two cycles with start asserted.
        rst_n      = 1'b0;
        bus.s      = 1'b1;
        bus.opcode = 3'b101;
        bus.op     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkOutput($sformatf("reset%0d", i), sampleOutputs(), waitOuts);
        end
        rst_n = 1'b1;
        applyStimulus(3'b101, 2'b00, 1'b0);

        // Table-driven per-instruction summaries.
        foreach (vecs[v]) begin
            bus.s      = 1'b1;
            bus.opcode = vecs[v].opcode;
            bus.op     = vecs[v].op;
            stepCycle();
            bus.s    = 1'b0;
            busy     = 0;
            writes   = 0;
            illegals = 0;
            execs    = 0;
            aluSeen  = 2'b00;
            for (int c = 0; c < 10; c++) begin
                if (bus.w) break;
                busy++;
                writes   += int'(bus.write);
                illegals += int'(bus.illegal);
                if (bus.loadc || bus.loads) begin
                    execs++;
                    aluSeen = bus.ALUop;
                end
                stepCycle();
            end
            checkValue($sformatf("vec%0d_busy", v), busy, vecs[v].busy);
            checkValue($sformatf("vec%0d_writes", v), writes, vecs[v].writes);
            checkValue($sformatf("vec%0d_illegal", v), illegals, vecs[v].illegals);
            checkValue($sformatf("vec%0d_execs", v), execs, vecs[v].execs);
            checkValue($sformatf("vec%0d_aluop", v), int'(aluSeen), int'(vecs[v].aluop));
        end

        // Opcode changed to 111 while the ADD sits in GET_A.
        buildExpected(3'b101, 2'b00);
        bus.s      = 1'b1;
        bus.opcode = 3'b101;
        bus.op     = 2'b00;
        stepCycle();
        bus.s = 1'b0;
        foreach (expQ[i]) begin
            if (i == 1) begin
                bus.opcode = 3'b111;
                bus.op     = 2'b11;
            end
            checkOutput($sformatf("stable%0d", i), sampleOutputs(), expQ[i]);
            stepCycle();
        end
        checkOutput("stableEndWait", sampleOutputs(), waitOuts);

        // Back-to-back starts with s held high throughout.
        applyStimulus(3'b101, 2'b00, 1'b1);
        applyStimulus(3'b110, 2'b10, 1'b1);
        applyStimulus(3'b101, 2'b01, 1'b1);
        applyStimulus(3'b101, 2'b11, 1'b0);

        // Reset during EXEC of an ADD aborts without writeback.
        bus.s      = 1'b1;
        bus.opcode = 3'b101;
        bus.op     = 2'b00;
        stepCycle();
        bus.s = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();
        checkValue("abortAtExec", int'(bus.loadc), 1);
        rst_n = 1'b0;
        stepCycle();
        checkOutput("abortReset", sampleOutputs(), waitOuts);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("abortAfter", sampleOutputs(), waitOuts);

        // Random instructions, mostly legal, with random idle gaps.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                oc = 3'($urandom);
                o  = 2'($urandom);
            end else begin
                case ($urandom_range(0, 5))
                    0: begin oc = 3'b110; o = 2'b10; end
                    1: begin oc = 3'b110; o = 2'b00; end
                    2: begin oc = 3'b101; o = 2'b00; end
                    3: begin oc = 3'b101; o = 2'b01; end
                    4: begin oc = 3'b101; o = 2'b10; end
                    default: begin oc = 3'b101; o = 2'b11; end
                endcase
            end
            applyStimulus(oc, o, 1'b0);
            bus.s = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                checkOutput($sformatf("gap%0d_%0d", n, g), sampleOutputs(), waitOuts);
                stepCycle();
            end
        end
        bus.s = 1'b0;
        checkOutput("finalWait", sampleOutputs(), waitOuts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
